// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit FIFO between the AES and plain block sources.
// Define UART_ARB_FIXED_PRIO_EN to make source 0 win every tie instead of alternating.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_AES      = 128
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  valid_0,
    input  logic [N_AES-1:0]      data_0,
    output logic                  ack_0,
    input  logic                  valid_1,
    input  logic [N_AES-1:0]      data_1,
    output logic                  ack_1,
    input  logic                  tx_full,
    output logic                  wren,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  busy,
    output logic                  owner,
    output logic                  blk_done
);

    localparam int NWORDS = N_AES / DATA_WIDTH;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [N_AES-1:0] shadow;
    logic [CW-1:0]    word_cnt;
    logic             last_owner;
    logic             any_req;
    logic             pick_1;

    always_comb begin
        any_req = valid_0 | valid_1;
`ifdef UART_ARB_FIXED_PRIO_EN
        pick_1 = valid_1 & ~valid_0;
`else
        // on a tie the source that did not own the previous block wins
        pick_1 = valid_1 & (~valid_0 | ~last_owner);
`endif
    end

    always_comb begin
        busy = (state == SEND);
        wren = (state == SEND) && !tx_full;
    end

    // word 0 is the most-significant slice of the captured block
    always_comb begin
        w_data = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (word_cnt == CW'(i)) begin
                w_data = shadow[N_AES-1-i*DATA_WIDTH -: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            shadow     <= '0;
            word_cnt   <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            ack_0      <= 1'b0;
            ack_1      <= 1'b0;
            blk_done   <= 1'b0;
        end else begin
            ack_0    <= 1'b0;
            ack_1    <= 1'b0;
            blk_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        shadow   <= pick_1 ? data_1 : data_0;
                        owner    <= pick_1;
                        word_cnt <= '0;
                        ack_0    <= ~pick_1;
                        ack_1    <= pick_1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (wren) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt   <= '0;
                            last_owner <= owner;
                            blk_done   <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single block, late arrival, back-pressure, reset mid-block, ties.
module tb_uart_tx_arbiter;

    logic         PCLK;
    logic         PRESETn;
    logic         valid_0;
    logic [127:0] data_0;
    logic         ack_0;
    logic         valid_1;
    logic [127:0] data_1;
    logic         ack_1;
    logic         tx_full;
    logic         wren;
    logic [31:0]  w_data;
    logic         busy;
    logic         owner;
    logic         blk_done;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    localparam logic [127:0] D3 = 128'h11110000_22220000_33330000_44440000;
    localparam logic [127:0] D4 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] D5 = 128'hFFFF0001_FFFF0002_FFFF0003_FFFF0004;
    localparam logic [127:0] T0 = 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D;
    localparam logic [127:0] T1 = 128'h50505050_60606060_70707070_80808080;

    uart_tx_arbiter #(.DATA_WIDTH(32), .N_AES(128)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .valid_0  (valid_0),
        .data_0   (data_0),
        .ack_0    (ack_0),
        .valid_1  (valid_1),
        .data_1   (data_1),
        .ack_1    (ack_1),
        .tx_full  (tx_full),
        .wren     (wren),
        .w_data   (w_data),
        .busy     (busy),
        .owner    (owner),
        .blk_done (blk_done)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] d, input int i);
        return d[127-32*i -: 32];
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Entered in the first cycle after a grant edge; leaves in the blk_done cycle.
    task automatic run_block(input string tag, input logic own, input logic [127:0] d,
                             input bit drop, input bit late, input logic [127:0] late_d);
        chk1({tag, " ack_0"}, ack_0, ~own);
        chk1({tag, " ack_1"}, ack_1, own);
        chk1({tag, " owner"}, owner, own);
        chk1({tag, " busy"}, busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk1({tag, " wren"}, wren, 1'b1);
            chk32({tag, " w_data"}, w_data, word_of(d, i));
            chk1({tag, " blk_done early"}, blk_done, 1'b0);
            if (i == 0 && drop) begin
                if (own) valid_1 = 1'b0;
                else     valid_0 = 1'b0;
            end
            if (i == 2 && late) begin
                valid_1 = 1'b1;
                data_1  = late_d;
            end
            tick();
        end
        chk1({tag, " blk_done"}, blk_done, 1'b1);
        chk1({tag, " busy end"}, busy, 1'b0);
        chk1({tag, " wren end"}, wren, 1'b0);
        chk1({tag, " ack_0 at done"}, ack_0, 1'b0);
        chk1({tag, " ack_1 at done"}, ack_1, 1'b0);
    endtask

    logic tie_own [3];

    initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
        tie_own = '{1'b0, 1'b0, 1'b0};
`else
        tie_own = '{1'b0, 1'b1, 1'b0};
`endif
        PRESETn = 1'b0;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        data_0  = '0;
        data_1  = '0;
        tx_full = 1'b0;

        // reset values
        repeat (2) @(posedge PCLK);
        #1;
        chk1("rst ack_0", ack_0, 1'b0);
        chk1("rst ack_1", ack_1, 1'b0);
        chk1("rst wren", wren, 1'b0);
        chk32("rst w_data", w_data, 32'h0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst owner", owner, 1'b0);
        chk1("rst blk_done", blk_done, 1'b0);
        PRESETn = 1'b1;
        tick();

        // single request, valid dropped the cycle after the grant edge
        valid_0 = 1'b1;
        data_0  = D0;
        tick();
        run_block("single", 1'b0, D0, 1'b1, 1'b0, '0);
        tick();
        chk1("single blk_done pulse", blk_done, 1'b0);
        chk1("single idle busy", busy, 1'b0);

        // late arrival of source 1 during the third word
        valid_0 = 1'b1;
        data_0  = D2;
        tick();
        run_block("late src0", 1'b0, D2, 1'b1, 1'b1, D3);
        tick();
        run_block("late src1", 1'b1, D3, 1'b1, 1'b0, '0);
        tick();
        chk1("late idle busy", busy, 1'b0);

        // back-pressure: stall three cycles while word 1 is presented
        valid_0 = 1'b1;
        data_0  = D4;
        tick();
        chk1("bp ack_0", ack_0, 1'b1);
        chk32("bp w0", w_data, word_of(D4, 0));
        chk1("bp wren w0", wren, 1'b1);
        valid_0 = 1'b0;
        tick();
        tx_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("bp stall wren", wren, 1'b0);
            chk32("bp stall w_data", w_data, word_of(D4, 1));
            chk1("bp stall busy", busy, 1'b1);
            chk1("bp stall blk_done", blk_done, 1'b0);
            tick();
        end
        tx_full = 1'b0;
        #1;
        for (int i = 1; i < 4; i++) begin
            chk1("bp resume wren", wren, 1'b1);
            chk32("bp resume w_data", w_data, word_of(D4, i));
            chk1("bp resume blk_done", blk_done, 1'b0);
            tick();
        end
        chk1("bp blk_done", blk_done, 1'b1);
        tick();

        // reset mid-block on a source 1 transfer
        valid_1 = 1'b1;
        data_1  = D5;
        tick();
        chk1("rmb owner", owner, 1'b1);
        chk32("rmb w0", w_data, word_of(D5, 0));
        valid_1 = 1'b0;
        tick();
        chk32("rmb w1", w_data, word_of(D5, 1));
        tick();
        chk1("rmb wren before rst", wren, 1'b1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk1("rmb wren", wren, 1'b0);
        chk32("rmb w_data", w_data, 32'h0);
        chk1("rmb busy", busy, 1'b0);
        chk1("rmb owner rst", owner, 1'b0);
        chk1("rmb ack_1", ack_1, 1'b0);
        tick();
        chk1("rmb blk_done", blk_done, 1'b0);
        @(posedge PCLK);
        #3;
        PRESETn = 1'b1;
        tick();
        chk1("rmb blk_done after", blk_done, 1'b0);

        // three-block tie with both requests held
        valid_0 = 1'b1;
        valid_1 = 1'b1;
        data_0  = T0;
        data_1  = T1;
        for (int b = 0; b < 3; b++) begin
            tick();
            run_block("tie", tie_own[b], tie_own[b] ? T1 : T0, 1'b0, 1'b0, '0);
        end
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        tick();
        chk1("tie final busy", busy, 1'b0);
        chk1("tie final blk_done", blk_done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit path, made up of the UART FIFO and its serializer, between two 128-bit block sources: the AES-encrypted path (source 0) and the plain APB concatenation path (source 1). It replaces the static source-select mux in front of the UART. Each granted block is captured into a shadow register and pushed into the UART FIFO as NWORDS words, honouring FIFO back-pressure. Blocks are never interleaved: a grant is held until the last word of the block is written.

## Interface
Parameters:
- DATA_WIDTH, 32, UART FIFO word width
- N_AES, 128, block width; must be an integer multiple of DATA_WIDTH
- NWORDS, N_AES/DATA_WIDTH (4), words per block; derived, not overridden

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low
- valid_0  in  1  source 0 (AES) block request
- data_0  in  N_AES  source 0 block
- ack_0  out  1  source 0 block accepted, one-cycle pulse
- valid_1  in  1  source 1 (plain) block request
- data_1  in  N_AES  source 1 block
- ack_1  out  1  source 1 block accepted, one-cycle pulse
- tx_full  in  1  UART FIFO full
- wren  out  1  UART FIFO write enable
- w_data  out  DATA_WIDTH  UART FIFO write data
- busy  out  1  block transfer in progress
- owner  out  1  source of the current or last granted block
- blk_done  out  1  last word of a block written, one-cycle pulse

## Operation
- States: IDLE and SEND. Reset state is IDLE.
- IDLE: if valid_0 or valid_1 is high, the arbiter picks a winner, latches the winner's data into `shadow`, sets owner, clears word_cnt and moves to SEND at the same edge. With no request it stays in IDLE.
- Arbitration (default) is round-robin. When only one source requests, that source wins. When both request, the winner is !last_owner. last_owner resets to 1, so source 0 wins the first tie.
- ack_x is registered. It is high for exactly the first SEND cycle following the grant. A source holds valid_x and data_x stable until it samples ack_x, then deasserts valid_x. Data is captured at the grant edge, so a source that drops valid_x after the grant edge still has its block sent.
- SEND: wren = (state==SEND) && !tx_full, combinational. w_data = shadow word word_cnt, most-significant word first: word 0 = shadow[N_AES-1 -: DATA_WIDTH].
- Each cycle with wren high, word_cnt increments. When wren is high with word_cnt==NWORDS-1: go to IDLE, last_owner ← owner, blk_done pulses next cycle (registered).
- tx_full high: wren=0, word_cnt holds, w_data holds. A stall has no timeout.
- busy = (state==SEND).
- word_cnt width is $clog2(NWORDS), minimum 1 bit.

## Timing
- Reset values: ack_0=ack_1=0, wren=0, w_data=0, busy=0, owner=0, blk_done=0. Internal state: shadow=0, word_cnt=0, last_owner=1.
- Reset asserted mid-block: all state clears immediately and asynchronously, wren drops immediately, and the partial block is discarded with no blk_done.
- Grant at edge E. ack_x, busy and the first wren are high in cycle E..E+1, provided tx_full is low.
- With no stalls, the 4 words occupy cycles E+0..E+3 after the grant and blk_done is high in cycle E+4. In cycle E+4 the state is IDLE, so a pending request is granted at the end of that cycle.
- Back-to-back throughput is therefore NWORDS+1 cycles per block. Each tx_full cycle adds one cycle.
- A request arriving during SEND waits. It is evaluated in the next IDLE cycle against the updated last_owner.
- blk_done and the ack of the next block never coincide; they are at least 1 cycle apart.

## Configuration
- UART_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Source 0 wins every tie. last_owner is still tracked but not used for arbitration.
  - Undefined: round-robin as described in Operation.
  - All other behaviour, including owner reporting, is identical in both builds.

## Test plan
- Single request: valid_0=1, data_0=128'h00112233_44556677_8899AABB_CCDDEEFF, tx_full=0. Required: ack_0 pulse; wren for 4 consecutive cycles with w_data 00112233, 44556677, 8899AABB, CCDDEEFF; blk_done one cycle later; owner=0.
- Tie, round-robin build: valid_0 and valid_1 held high for 3 blocks. Grants go 0, 1, 0; each block is 5 cycles apart; acks alternate. With UART_ARB_FIXED_PRIO_EN defined, grants go 0, 0, 0 while valid_0 is held.
- Back-pressure: tx_full=1 for 3 cycles after the second word. wren=0 during the stall, w_data holds word 1, the remaining words follow, and blk_done is delayed by exactly 3 cycles.
- Late arrival: valid_1 rises during the third word of a source 0 block. Source 1 is granted in the blk_done cycle with no lost words.
- Reset mid-block: PRESETn is asserted after word 1. wren drops immediately, all outputs take their reset values, and after release the next tie is granted to source 0.
- Early valid drop: valid_0 deasserts one cycle after the grant edge. All 4 words of the captured block are still sent.
